// File: rtl/serdes_align_pkg.sv
// Shared types and default constants for the serial word aligner.
package serdes_align_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    localparam int         DEF_WIDTH        = 8;
    localparam logic [7:0] DEF_SYNC_PATTERN = 8'hA5;
    localparam int         DEF_LOCK_COUNT   = 3;
    localparam int         DEF_LOSS_GAP     = 4;

    // Match and gap counters never need more than 4 bits (limits are 1..15).
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/serdes_word_aligner.sv
// Recovers word alignment from a gated serial bit stream using a repeated sync word,
// then emits deserialized words with an optional channel-bond marker.
module serdes_word_aligner
    import serdes_align_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC_PATTERN),
    parameter int               LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int               LOSS_GAP     = DEF_LOSS_GAP
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             bond_sync_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             bond_sync_out,
    output logic             align_err
);

    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = LOCK_COUNT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] GAP_LIM  = LOSS_GAP[CNT_W-1:0];

    align_state_t     r_state;
    logic [WIDTH-2:0] r_shift;
    logic [CW-1:0]    r_bitCnt;
    logic [CNT_W-1:0] r_match;
    logic [CNT_W-1:0] r_gap;
    logic             r_bondPend;
    logic [WIDTH-1:0] r_word;
    logic             r_wordValid;
    logic             r_bondOut;
    logic             r_alignErr;

    align_state_t     w_stateNext;
    logic [WIDTH-1:0] w_shiftNext;
    logic [CW-1:0]    w_bitCntNext;
    logic [CNT_W-1:0] w_matchNext;
    logic [CNT_W-1:0] w_matchInc;
    logic [CNT_W-1:0] w_gapNext;
    logic             w_bondPendNext;
    logic [WIDTH-1:0] w_wordNext;
    logic             w_wordValidNext;
    logic             w_bondOutNext;
    logic             w_alignErrNext;
    logic             w_boundary;
    logic             w_gapLoss;
    logic             w_isSync;

    // Only the low WIDTH-1 bits are stored; the incoming bit completes the window.
    assign w_shiftNext = {r_shift, serial_in};
    assign w_isSync    = (w_shiftNext == SYNC_PATTERN);
    assign w_boundary  = serial_valid && (r_bitCnt == LAST_BIT);
    assign w_matchInc  = r_match + 4'd1;
    assign w_gapNext   = serial_valid ? '0 : satInc(r_gap);
    assign w_gapLoss   = !serial_valid && (w_gapNext >= GAP_LIM);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_bitCntNext    = r_bitCnt;
        w_matchNext     = r_match;
        w_bondPendNext  = r_bondPend;
        w_wordNext      = r_word;
        w_wordValidNext = 1'b0;
        w_bondOutNext   = 1'b0;
        w_alignErrNext  = 1'b0;

        if (serial_valid) begin
            w_bitCntNext = (r_bitCnt == LAST_BIT) ? '0 : r_bitCnt + 1'b1;
        end

        case (r_state)
            HUNT: begin
                w_bondPendNext = 1'b0;
                if (serial_valid && w_isSync) begin
                    // The sync word just completed, so the next bit opens a new word.
                    w_bitCntNext = '0;
                    w_matchNext  = 4'd1;
                    w_stateNext  = (LOCK_LIM == 4'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                w_bondPendNext = 1'b0;
                if (w_gapLoss) begin
                    w_matchNext = '0;
                    w_stateNext = HUNT;
                end else if (w_boundary) begin
                    if (w_isSync) begin
                        w_matchNext = w_matchInc;
                        if (w_matchInc >= LOCK_LIM) begin
                            w_stateNext = LOCKED;
                        end
                    end else begin
                        w_matchNext    = '0;
                        w_alignErrNext = 1'b1;
                        w_stateNext    = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (w_gapLoss) begin
                    w_bondPendNext = 1'b0;
                    w_matchNext    = '0;
                    w_stateNext    = HUNT;
                end else if (w_boundary) begin
                    // A marker arriving on the boundary bit belongs to the word it completes.
                    w_wordNext      = w_shiftNext;
                    w_wordValidNext = 1'b1;
                    w_bondOutNext   = r_bondPend || bond_sync_in;
                    w_bondPendNext  = 1'b0;
                end else if (bond_sync_in) begin
                    w_bondPendNext = 1'b1;
                end
            end
            default: begin
                w_stateNext = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_match     <= '0;
            r_gap       <= '0;
            r_bondPend  <= 1'b0;
            r_word      <= '0;
            r_wordValid <= 1'b0;
            r_bondOut   <= 1'b0;
            r_alignErr  <= 1'b0;
        end else begin
            if (serial_valid) begin
                r_shift <= w_shiftNext[WIDTH-2:0];
            end
            r_bitCnt    <= w_bitCntNext;
            r_match     <= w_matchNext;
            r_gap       <= w_gapNext;
            r_bondPend  <= w_bondPendNext;
            r_word      <= w_wordNext;
            r_wordValid <= w_wordValidNext;
            r_bondOut   <= w_bondOutNext;
            r_alignErr  <= w_alignErrNext;
        end
    end

    assign word_out      = r_word;
    assign word_valid    = r_wordValid;
    assign locked        = (r_state == LOCKED);
    assign bond_sync_out = r_bondOut;
    assign align_err     = r_alignErr;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Directed bench for serdes_word_aligner: lock acquisition, verify failure, gap loss,
// bond marker alignment and reset behaviour with hand-computed expectations.
module tb_serdes_word_aligner;

    logic       clk_in;
    logic       reset;
    logic       serial_in;
    logic       serial_valid;
    logic       bond_sync_in;
    logic [7:0] word_out;
    logic       word_valid;
    logic       locked;
    logic       bond_sync_out;
    logic       align_err;

    int testCount;
    int failCount;
    int wvCount;
    int errCount;
    int bondCount;

    serdes_word_aligner #(
        .WIDTH       (8),
        .SYNC_PATTERN(8'hA5),
        .LOCK_COUNT  (3),
        .LOSS_GAP    (4)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .bond_sync_in (bond_sync_in),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .locked       (locked),
        .bond_sync_out(bond_sync_out),
        .align_err    (align_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 ns after the rising edge.
    task automatic applyStimulus(input logic b, input logic v, input logic bs);
        @(negedge clk_in);
        serial_in    = b;
        serial_valid = v;
        bond_sync_in = bs;
        @(posedge clk_in);
        #1;
        wvCount   += int'(word_valid);
        errCount  += int'(align_err);
        bondCount += int'(bond_sync_out);
    endtask

    // Sends bits fromIdx..toIdx of w, index 0 being the MSB; bondIdx raises bond_sync_in.
    task automatic sendBits(input logic [7:0] w, input int fromIdx, input int toIdx, input int bondIdx);
        for (int i = fromIdx; i <= toIdx; i++) begin
            applyStimulus(w[7-i], 1'b1, (i == bondIdx));
        end
    endtask

    task automatic sendWord(input logic [7:0] w, input int bondIdx);
        sendBits(w, 0, 7, bondIdx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        testCount    = 0;
        failCount    = 0;
        wvCount      = 0;
        errCount     = 0;
        bondCount    = 0;
        reset        = 1'b1;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        bond_sync_in = 1'b0;

        // Reset held while random valid bits arrive.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
        end
        checkOutput("rst_word_out", 32'(word_out), 32'h0);
        checkOutput("rst_word_valid", 32'(word_valid), 32'h0);
        checkOutput("rst_locked", 32'(locked), 32'h0);
        checkOutput("rst_bond_out", 32'(bond_sync_out), 32'h0);
        checkOutput("rst_align_err", 32'(align_err), 32'h0);
        reset = 1'b0;
        idle(1);
        checkOutput("post_rst_locked", 32'(locked), 32'h0);

        // Three garbage bits, then three sync words and a data word.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        sendWord(8'hA5, -1);
        checkOutput("verify1_locked", 32'(locked), 32'h0);
        sendWord(8'hA5, -1);
        checkOutput("verify2_locked", 32'(locked), 32'h0);
        sendWord(8'hA5, -1);
        checkOutput("lock_locked", 32'(locked), 32'h1);
        checkOutput("lock_no_wv", 32'(wvCount), 32'h0);
        sendWord(8'h3C, -1);
        checkOutput("w3c_valid", 32'(word_valid), 32'h1);
        checkOutput("w3c_word", 32'(word_out), 32'h3C);
        checkOutput("w3c_count", 32'(wvCount), 32'h1);
        idle(1);
        checkOutput("w3c_pulse_end", 32'(word_valid), 32'h0);
        checkOutput("w3c_hold", 32'(word_out), 32'h3C);

        // Sync pattern inside locked data stream is plain data.
        sendWord(8'hA5, -1);
        checkOutput("data_a5_word", 32'(word_out), 32'hA5);
        sendWord(8'h12, -1);
        checkOutput("data_12_word", 32'(word_out), 32'h12);
        checkOutput("data_12_locked", 32'(locked), 32'h1);

        // Three-cycle gap mid-word survives.
        sendBits(8'h96, 0, 3, -1);
        idle(3);
        checkOutput("gap3_locked", 32'(locked), 32'h1);
        checkOutput("gap3_hold", 32'(word_out), 32'h12);
        sendBits(8'h96, 4, 7, -1);
        checkOutput("gap3_valid", 32'(word_valid), 32'h1);
        checkOutput("gap3_word", 32'(word_out), 32'h96);

        // Four-cycle gap drops lock without a word or error.
        wvCount  = 0;
        errCount = 0;
        sendBits(8'h00, 0, 1, -1);
        idle(3);
        checkOutput("gap4_pre_locked", 32'(locked), 32'h1);
        idle(1);
        checkOutput("gap4_locked", 32'(locked), 32'h0);
        checkOutput("gap4_no_wv", 32'(wvCount), 32'h0);
        checkOutput("gap4_no_err", 32'(errCount), 32'h0);

        // Re-lock, then bond marker mid-word and on the boundary bit.
        sendWord(8'h00, -1);
        sendWord(8'hA5, -1);
        sendWord(8'hA5, -1);
        sendWord(8'hA5, -1);
        checkOutput("relock_locked", 32'(locked), 32'h1);
        bondCount = 0;
        sendWord(8'hC6, 3);
        checkOutput("bond_c6_valid", 32'(word_valid), 32'h1);
        checkOutput("bond_c6_word", 32'(word_out), 32'hC6);
        checkOutput("bond_c6_out", 32'(bond_sync_out), 32'h1);
        sendWord(8'h00, -1);
        checkOutput("bond_next_out", 32'(bond_sync_out), 32'h0);
        checkOutput("bond_count", 32'(bondCount), 32'h1);
        sendWord(8'h7E, 7);
        checkOutput("bond_edge_out", 32'(bond_sync_out), 32'h1);
        checkOutput("bond_edge_word", 32'(word_out), 32'h7E);

        // Verify failure: A5 followed by 5A.
        idle(4);
        checkOutput("drop2_locked", 32'(locked), 32'h0);
        sendWord(8'h00, -1);
        errCount = 0;
        sendWord(8'hA5, -1);
        sendWord(8'h5A, -1);
        checkOutput("verr_pulse", 32'(align_err), 32'h1);
        checkOutput("verr_locked", 32'(locked), 32'h0);
        idle(1);
        checkOutput("verr_pulse_end", 32'(align_err), 32'h0);
        checkOutput("verr_count", 32'(errCount), 32'h1);
        sendWord(8'h00, -1);
        sendWord(8'hA5, -1);
        sendWord(8'hA5, -1);
        checkOutput("verr_relock_pre", 32'(locked), 32'h0);
        sendWord(8'hA5, -1);
        checkOutput("verr_relock", 32'(locked), 32'h1);
        sendWord(8'h81, -1);
        checkOutput("verr_data", 32'(word_out), 32'h81);

        // Reset while locked, then reset in the middle of the second verify word.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        checkOutput("rst2_word_out", 32'(word_out), 32'h0);
        checkOutput("rst2_locked", 32'(locked), 32'h0);
        sendWord(8'h00, -1);
        sendWord(8'hA5, -1);
        sendBits(8'hA5, 0, 3, -1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        checkOutput("rst3_locked", 32'(locked), 32'h0);
        checkOutput("rst3_word_valid", 32'(word_valid), 32'h0);
        checkOutput("rst3_align_err", 32'(align_err), 32'h0);
        sendBits(8'hA5, 4, 7, -1);
        sendWord(8'hA5, -1);
        sendWord(8'hA5, -1);
        checkOutput("rst3_no_lock", 32'(locked), 32'h0);
        sendWord(8'hA5, -1);
        checkOutput("rst3_fresh_lock", 32'(locked), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
